// File: rtl/arp_req_parse.sv
// Receive-side ARP request parser: reads offsets 12..41 of a stored frame, checks for an
// ARP request addressed to LOCAL_IP, latches the sender MAC/IP and hands off to the reply builder.
module arp_req_parse #(
  parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0A02,
  parameter logic [9:0]  FRAME_BASE = 10'd0,
  parameter int          RD_LAT     = 2
) (
  input  logic        iDm9000aClk,
  input  logic        iRst_n,
  input  logic        iRunStart,
  output logic [9:0]  oRamAddr,
  output logic        oRamRden,
  input  logic [7:0]  iRamQ,
  output logic [47:0] oMacPc,
  output logic [31:0] oIpPc,
  output logic        oArpReq,
  input  logic        iAckDone,
  output logic        oDone,
  output logic        oDrop,
  output logic        oBusy
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_REQ} state_t;

  state_t            r_state;
  logic [4:0]        r_iss;
  logic [4:0]        r_idx;
  logic [RD_LAT-1:0] r_pipe;
  logic              r_bad;

  logic              w_issue;
  logic [RD_LAT:0]   w_pipe_nx;
  logic              w_cmp_vld;
  logic [8:0]        w_exp;
  logic              w_miss;
  logic              w_last;
  logic              w_bad_final;

  // {check-enable, expected byte} for compare index idx (frame offset 12+idx)
  function automatic logic [8:0] exp_byte(input logic [4:0] idx);
    logic [8:0] v;
    case (idx)
      5'd0:    v = 9'h108;
      5'd1:    v = 9'h106;
      5'd2:    v = 9'h100;
      5'd3:    v = 9'h101;
      5'd4:    v = 9'h108;
      5'd5:    v = 9'h100;
      5'd6:    v = 9'h106;
      5'd7:    v = 9'h104;
      5'd8:    v = 9'h100;
      5'd9:    v = 9'h101;
      5'd26:   v = {1'b1, LOCAL_IP[31:24]};
      5'd27:   v = {1'b1, LOCAL_IP[23:16]};
      5'd28:   v = {1'b1, LOCAL_IP[15:8]};
      5'd29:   v = {1'b1, LOCAL_IP[7:0]};
      default: v = 9'h000;
    endcase
    return v;
  endfunction

  assign w_issue     = (r_state == S_READ);
  assign w_pipe_nx   = {r_pipe, w_issue};
  assign w_cmp_vld   = r_pipe[RD_LAT-1];
  assign w_exp       = exp_byte(r_idx);
  assign w_miss      = w_cmp_vld & w_exp[8] & (iRamQ != w_exp[7:0]);
  assign w_last      = w_cmp_vld & (r_idx == 5'd29);
  assign w_bad_final = r_bad | w_miss;

  // Issue/compare sequencing, field capture and the handshake FSM
  always_ff @(posedge iDm9000aClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state  <= S_IDLE;
      r_iss    <= 5'd0;
      r_idx    <= 5'd0;
      r_pipe   <= '0;
      r_bad    <= 1'b0;
      oRamAddr <= 10'd0;
      oRamRden <= 1'b0;
      oMacPc   <= 48'd0;
      oIpPc    <= 32'd0;
      oArpReq  <= 1'b0;
      oDone    <= 1'b0;
      oDrop    <= 1'b0;
      oBusy    <= 1'b0;
    end else begin
      oDone  <= 1'b0;
      oDrop  <= 1'b0;
      r_pipe <= w_pipe_nx[RD_LAT-1:0];

      // The compare index trails the issue counter by the RAM latency
      if (w_cmp_vld) begin
        r_idx <= r_idx + 5'd1;
        if (w_miss) begin
          r_bad <= 1'b1;
        end
        if (r_idx >= 5'd10 && r_idx <= 5'd15) begin
          oMacPc <= {oMacPc[39:0], iRamQ};
        end
        if (r_idx >= 5'd16 && r_idx <= 5'd19) begin
          oIpPc <= {oIpPc[23:0], iRamQ};
        end
      end

      case (r_state)
        S_IDLE: begin
          if (iRunStart) begin
            r_bad    <= 1'b0;
            r_iss    <= 5'd0;
            r_idx    <= 5'd0;
            oRamAddr <= FRAME_BASE + 10'd12;
            oRamRden <= 1'b1;
            oBusy    <= 1'b1;
            r_state  <= S_READ;
          end
        end
        S_READ: begin
          if (r_iss == 5'd29) begin
            oRamRden <= 1'b0;
            r_state  <= S_DRAIN;
          end else begin
            r_iss    <= r_iss + 5'd1;
            oRamAddr <= FRAME_BASE + 10'd13 + {5'd0, r_iss};
          end
        end
        S_DRAIN: begin
          // Verdict is taken on the edge that compares the last byte
          if (w_last) begin
            oDone <= 1'b1;
            if (w_bad_final) begin
              oDrop   <= 1'b1;
              oBusy   <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              oArpReq <= 1'b1;
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (iAckDone) begin
            oArpReq <= 1'b0;
            oBusy   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arp_req_parse.sv
// Scoreboard bench: three parsers (RD_LAT 1..3) share stimulus; a reference model predicts
// each frame's verdict, fields and oDone cycle, and per-DUT monitors compare on oDone.
module tb_arp_req_parse;

  localparam logic [31:0] LIP = 32'hC0A8_0A02;

  typedef struct {
    int          cyc;
    bit          drop;
    logic [47:0] mac;
    logic [31:0] ip;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n, start, ack;
  logic [7:0] mem [0:1023];
  exp_t sb [3][$];
  int n_cmp = 0;
  int n_bad = 0;

  logic [9:0]  addr_o [3];
  logic        rden_o [3];
  logic [47:0] mac_o  [3];
  logic [31:0] ip_o   [3];
  logic        req_o  [3];
  logic        done_o [3];
  logic        drop_o [3];
  logic        busy_o [3];

  task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d at cycle %0d: got %0h expected %0h", nm, g, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [7:0] d1, d2, d3, ramq;
    always @(posedge clk) begin
      d1 <= mem[addr_o[g]];
      d2 <= d1;
      d3 <= d2;
    end
    assign ramq = (g == 0) ? d1 : ((g == 1) ? d2 : d3);

    arp_req_parse #(.LOCAL_IP(LIP), .FRAME_BASE(10'd0), .RD_LAT(g + 1)) u_dut (
      .iDm9000aClk(clk),
      .iRst_n     (rst_n),
      .iRunStart  (start),
      .oRamAddr   (addr_o[g]),
      .oRamRden   (rden_o[g]),
      .iRamQ      (ramq),
      .oMacPc     (mac_o[g]),
      .oIpPc      (ip_o[g]),
      .oArpReq    (req_o[g]),
      .iAckDone   (ack),
      .oDone      (done_o[g]),
      .oDrop      (drop_o[g]),
      .oBusy      (busy_o[g])
    );

    always @(negedge clk) begin
      if (rst_n === 1'b1) begin
        if (done_o[g]) begin
          if (sb[g].size() == 0) begin
            chk("unexpected_done", g, 64'd1, 64'd0);
          end else begin
            exp_t e;
            e = sb[g].pop_front();
            chk("done_cycle", g, 64'(cyc), 64'(e.cyc));
            chk("drop", g, 64'(drop_o[g]), 64'(e.drop));
            chk("arpreq_at_done", g, 64'(req_o[g]), 64'(!e.drop));
            if (!e.drop) begin
              chk("mac", g, 64'(mac_o[g]), 64'(e.mac));
              chk("ip", g, 64'(ip_o[g]), 64'(e.ip));
            end
          end
        end else if (drop_o[g]) begin
          chk("drop_without_done", g, 64'd1, 64'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string nm);
    for (int g = 0; g < 3; g++) begin
      chk({nm, "_addr"}, g, 64'(addr_o[g]), 64'd0);
      chk({nm, "_rden"}, g, 64'(rden_o[g]), 64'd0);
      chk({nm, "_mac"},  g, 64'(mac_o[g]),  64'd0);
      chk({nm, "_ip"},   g, 64'(ip_o[g]),   64'd0);
      chk({nm, "_req"},  g, 64'(req_o[g]),  64'd0);
      chk({nm, "_done"}, g, 64'(done_o[g]), 64'd0);
      chk({nm, "_drop"}, g, 64'(drop_o[g]), 64'd0);
      chk({nm, "_busy"}, g, 64'(busy_o[g]), 64'd0);
    end
  endtask

  // kind: 0 valid, 1 wrong target IP, 2 ARP reply, 3 IPv4 ethertype, 4 offset-12 error,
  // 5 offset-41 error, 6 one random checked byte flipped
  task automatic build_frame(input int kind, input logic [47:0] mac, input logic [31:0] ip);
    logic [7:0] hdr [10] = '{8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01};
    int off;
    for (int i = 0; i < 10; i++) mem[12 + i] = hdr[i];
    for (int i = 0; i < 6; i++) mem[22 + i] = mac[47 - 8 * i -: 8];
    for (int i = 0; i < 4; i++) mem[28 + i] = ip[31 - 8 * i -: 8];
    for (int i = 32; i < 38; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) mem[38 + i] = LIP[31 - 8 * i -: 8];
    case (kind)
      1: mem[41] = 8'h03;
      2: mem[21] = 8'h02;
      3: mem[13] = 8'h00;
      4: mem[12] = mem[12] ^ 8'h80;
      5: mem[41] = mem[41] ^ 8'h10;
      6: begin
        off = $urandom_range(0, 13);
        off = (off < 10) ? 12 + off : 28 + off;
        mem[off] = mem[off] ^ (8'd1 << $urandom_range(0, 7));
      end
      default: ;
    endcase
  endtask

  task automatic ref_model(output bit drop, output logic [47:0] m, output logic [31:0] ip);
    logic [7:0] want [10] = '{8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01};
    drop = 1'b0;
    for (int i = 0; i < 10; i++) if (mem[12 + i] != want[i]) drop = 1'b1;
    if ({mem[38], mem[39], mem[40], mem[41]} != LIP) drop = 1'b1;
    m  = {mem[22], mem[23], mem[24], mem[25], mem[26], mem[27]};
    ip = {mem[28], mem[29], mem[30], mem[31]};
  endtask

  task automatic run_frame(input int kind, input bit extra, input logic [47:0] mac,
                           input logic [31:0] ip, input bit rst_mid);
    int st;
    bit drop;
    logic [47:0] emac;
    logic [31:0] eip;
    exp_t e;
    build_frame(kind, mac, ip);
    ref_model(drop, emac, eip);
    tick();
    tick();
    start = 1'b1;
    st = cyc;
    if (!rst_mid) begin
      for (int g = 0; g < 3; g++) begin
        e.cyc = st + 32 + g;
        e.drop = drop;
        e.mac = emac;
        e.ip = eip;
        sb[g].push_back(e);
      end
    end
    tick();
    start = 1'b0;
    while (cyc < st + 36) begin
      start = extra && (cyc == st + 10);
      if (cyc == st + 5) begin
        for (int g = 0; g < 3; g++) chk("busy_mid", g, 64'(busy_o[g]), 64'd1);
      end
      if (rst_mid && cyc == st + 15) begin
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
      end
      tick();
    end
    start = 1'b0;
    for (int g = 0; g < 3; g++) begin
      chk("missing_done", g, 64'(sb[g].size()), 64'd0);
      sb[g].delete();
    end
    if (rst_mid) return;
    for (int g = 0; g < 3; g++) begin
      chk("arpreq_hold", g, 64'(req_o[g]), 64'(!drop));
      chk("busy_after", g, 64'(busy_o[g]), 64'(!drop));
    end
    if (!drop) begin
      while (cyc < st + 40) begin
        start = extra && (cyc == st + 37);
        tick();
      end
      ack = 1'b1;
      start = extra;
      tick();
      ack = 1'b0;
      start = 1'b0;
      for (int g = 0; g < 3; g++) begin
        chk("arpreq_after_ack", g, 64'(req_o[g]), 64'd0);
        chk("busy_after_ack", g, 64'(busy_o[g]), 64'd0);
        chk("mac_stable", g, 64'(mac_o[g]), 64'(emac));
        chk("ip_stable", g, 64'(ip_o[g]), 64'(eip));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    ack = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    tick();
    tick();
    ack = 1'b1;
    start = 1'b1;
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    ack = 1'b0;
    start = 1'b0;
    rst_n = 1'b1;
    tick();

    run_frame(0, 1'b0, 48'h001B213A4F10, 32'hC0A80A01, 1'b0);
    for (int k = 1; k <= 5; k++) run_frame(k, 1'b0, 48'h001B213A4F10, 32'hC0A80A01, 1'b0);
    run_frame(0, 1'b0, 48'h001B213A4F10, 32'hC0A80A01, 1'b1);
    tick();
    for (int i = 0; i < 30; i++) tick();
    run_frame(0, 1'b0, 48'h001B213A4F10, 32'hC0A80A01, 1'b0);
    run_frame(0, 1'b1, 48'h0A0B0C0D0E0F, 32'h0A000001, 1'b0);
    for (int n = 0; n < 24; n++) begin
      run_frame($urandom_range(0, 6), 1'($urandom_range(0, 1)),
                {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF, $urandom, 1'b0);
    end
    for (int i = 0; i < 5; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
